// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; radix-2 shift-add multiply, restoring divide.
// Latency WIDTH+1 edges start-to-done; start ignored while busy except on the completing edge.
module muldiv_unit #(
   parameter int WIDTH     = 32,
   parameter bit FAST_ZERO = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cancel_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div0_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mpl_q, mpl_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             is_div_q, is_div_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q;
   logic             done_q, done_d;
   logic             div0_q, div0_d;

   logic             is_md, is_sgn, is_dv, mt_hi, mt_lo, accept, fast_zero;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   mul_sum, shifted, diff;
   logic             ge;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0] quo_s, rem_s;

   assign is_md  = ~op_i[2];
   assign is_sgn = ~op_i[0];
   assign is_dv  = op_i[1];
   assign mt_hi  = (op_i == 3'b100);
   assign mt_lo  = (op_i == 3'b101);
   assign abs_a  = (is_sgn && a_i[WIDTH-1]) ? -a_i : a_i;
   assign abs_b  = (is_sgn && b_i[WIDTH-1]) ? -b_i : b_i;
   assign fast_zero = FAST_ZERO && !is_dv && ((a_i == '0) || (b_i == '0));

   // The completing FIX edge also accepts a new request so ops can run back-to-back.
   assign accept = start_i && ((state_q == S_IDLE) || (state_q == S_FIX && !cancel_i));

   assign mul_sum = mpl_q[0] ? ({1'b0, acc_q} + {1'b0, dvs_q}) : {1'b0, acc_q};
   assign shifted = {acc_q, mpl_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs_q};
   assign ge      = (shifted >= {1'b0, dvs_q});

   assign prod   = {acc_q, mpl_q};
   assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
   assign quo_s  = (sa_q ^ sb_q) ? -mpl_q : mpl_q;
   // With a zero divisor the remainder path ends holding |a|, so restoring its sign yields a.
   assign rem_s  = sa_q ? -acc_q : acc_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mpl_d    = mpl_q;
      dvs_d    = dvs_q;
      is_div_d = is_div_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      div0_d   = 1'b0;

      case (state_q)
         S_CALC: begin
            if (cancel_i) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) state_d = S_FIX;
               if (is_div_q) begin
                  acc_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                  mpl_d = {mpl_q[WIDTH-2:0], ge};
               end else begin
                  acc_d = mul_sum[WIDTH:1];
                  mpl_d = {mul_sum[0], mpl_q[WIDTH-1:1]};
               end
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!cancel_i) begin
               done_d = 1'b1;
               div0_d = dz_q;
               if (is_div_q) begin
                  hi_d = rem_s;
                  lo_d = dz_q ? '1 : quo_s;
               end else begin
                  hi_d = prod_s[2*WIDTH-1:WIDTH];
                  lo_d = prod_s[WIDTH-1:0];
               end
            end
         end
         default: ;
      endcase

      if (accept) begin
         if (is_md) begin
            state_d  = fast_zero ? S_FIX : S_CALC;
            cnt_d    = CW'(WIDTH);
            acc_d    = '0;
            is_div_d = is_dv;
            sa_d     = is_sgn & a_i[WIDTH-1];
            sb_d     = is_sgn & b_i[WIDTH-1];
            dz_d     = is_dv && (b_i == '0);
            if (is_dv) begin
               mpl_d = abs_a;
               dvs_d = abs_b;
            end else begin
               mpl_d = fast_zero ? '0 : abs_b;
               dvs_d = abs_a;
            end
         end else if (mt_hi) begin
            hi_d = a_i;
         end else if (mt_lo) begin
            lo_d = a_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mpl_q    <= '0;
         dvs_q    <= '0;
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mpl_q    <= mpl_d;
         dvs_q    <= dvs_d;
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= (state_d != S_IDLE);
         done_q   <= done_d;
         div0_q   <= div0_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign div0_o = div0_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule
